wd_window_monitor: RTL and testbench
====================================

# wd_window_monitor

Multi-channel windowed watchdog fail detector, the parametrised successor to the single-channel watchdog fail detector in the safety-critical watchdog path. Each of NCH software channels reports its run status and issues service strobes. Per channel, a cycle counter checks that each service lands inside a [WIN_MIN, WIN_MAX] window. Faults are latched with a 3-bit status code, and a firmware override forces all channels to fail.

## Interface
- NCH, 4: number of monitored channels (1..16)
- CNT_W, 16: window counter width
- WIN_MIN, 100: earliest legal service, in cycles since arm/last service (≥1)
- WIN_MAX, 1000: latest legal service (WIN_MIN < WIN_MAX < 2^CNT_W)
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  asynchronous, active-low reset
- SWSTAT  in  NCH  per-channel software running status (level)
- WDSRVC  in  NCH  per-channel service strobe; rising edge detected internally
- FWOVR  in  1  firmware override, global, level
- CLRFAIL  in  1  clears latched faults on all channels (level, sampled each cycle)
- WDFAIL  out  NCH  per-channel fail flag
- FLSTAT  out  3*NCH  per-channel fault code, channel i at [3i+2:3i]
- WDFAIL_ANY  out  1  OR of WDFAIL

## Operation
- Inputs are synchronous to CLK. Asynchronous sources are synchronised upstream.
- Service edge: SRVC_EDGE[i] = WDSRVC[i] & ~WDSRVC_q[i]. WDSRVC_q resets to 0.
- Fault codes:
  - 000: firmware override
  - 001: service while SWSTAT=0
  - 010: early service (cnt < WIN_MIN)
  - 011: SWSTAT fell with no accepted service since arm
  - 100: window timeout
  - 111: no fault
- Per-channel FSM states:
  - IDLE:
    - SWSTAT=1 → ARMED, cnt=0, SRVD=0.
    - SRVC_EDGE → FAIL(001).
  - ARMED (cnt < WIN_MIN):
    - cnt increments.
    - SRVC_EDGE → FAIL(010).
    - Reaching cnt=WIN_MIN → OPEN.
  - OPEN (WIN_MIN ≤ cnt ≤ WIN_MAX):
    - SRVC_EDGE → ARMED, cnt=0, SRVD=1.
    - cnt=WIN_MAX with no edge → FAIL(100).
  - ARMED/OPEN, SWSTAT=0:
    - SRVD=1 → IDLE, clean.
    - SRVD=0 → FAIL(011).
    - Takes precedence over a same-cycle service edge.
  - FAIL:
    - WDFAIL=1 and FLSTAT holds the first fault code. Later channel events are ignored.
    - CLRFAIL=1 with FWOVR=0 → IDLE, WDFAIL=0, FLSTAT=111.
- FWOVR=1: every channel → FAIL(000), overwriting any latched code. CLRFAIL is ignored while FWOVR=1.
- Per-channel priority: FWOVR > CLRFAIL > SWSTAT fall > service edge > timeout.
- Counter saturates at 2^CNT_W−1. It never wraps, and saturation is unreachable in legal operation.
- After a clear with SWSTAT still 1, the channel re-arms from IDLE on the next cycle with cnt=0.

## Timing
- Reset (RST_N=0, asynchronous): all channels IDLE, cnt=0, SRVD=0, WDFAIL=0, FLSTAT all 111, WDFAIL_ANY=0.
- Reset deassertion is used synchronously by the design.
- Latency: a condition sampled at edge k is visible on WDFAIL/FLSTAT after edge k. WDFAIL_ANY is combinational from WDFAIL with no extra cycle.
- WDSRVC held high counts as one service. A new service requires a low cycle in between.
- Timeout fault registers at the edge where cnt=WIN_MAX with no edge: WIN_MAX+1 cycles after arming or after the last accepted service (arm edge = cnt 0).
- FWOVR: all channels show 000 one edge after FWOVR is sampled high.
- CLRFAIL: takes effect one edge after it is sampled high.

## Structure
- Shared package wd_pkg holds:
  - fault-code constants FC_OVR, FC_NOSW, FC_EARLY, FC_SWDROP, FC_TMO, FC_NONE
  - channel state encoding IDLE/ARMED/OPEN/FAIL (2 bits)
- Sub-module wd_window_channel implements one channel: FSM, counter, SRVD, edge register and fault latch, with WIN_MIN/WIN_MAX/CNT_W passed through.
- Top level holds a generate loop over NCH, FLSTAT packing and the WDFAIL_ANY reduction.

## Test plan
Bench parameters: NCH=2, CNT_W=8, WIN_MIN=4, WIN_MAX=10.
- Reset: RST_N low mid-operation → immediately WDFAIL=00, FLSTAT=111111, WDFAIL_ANY=0.
- Legal run: SWSTAT[0]=1; service edges at cnt 5, then cnt 9; SWSTAT[0]→0 → WDFAIL[0] stays 0, FLSTAT[2:0]=111, channel returns to IDLE.
- Early and no-run service: service at cnt 2 → next edge WDFAIL[0]=1, FLSTAT[2:0]=010. Service on ch1 with SWSTAT[1]=0 → FLSTAT[5:3]=001. A later timeout on ch0 leaves 010 latched.
- Timeout and drop: arm ch0 with no service → WDFAIL[0] rises exactly 11 cycles after arming, FLSTAT[2:0]=100. Arm ch1 and drop SWSTAT at cnt 3 → FLSTAT[5:3]=011.
- Override/clear: with ch1 latched at 010, pulse FWOVR → FLSTAT=000000, WDFAIL=11. CLRFAIL with FWOVR=1 → no change. CLRFAIL after FWOVR=0 → FLSTAT=111111, WDFAIL=00.
- Simultaneous events: SWSTAT fall and service edge in the same cycle with SRVD=0 → 011. Service edge at exactly cnt=10 → accepted, no fault.

Source files
------------

// File: rtl/wd_pkg.sv
// Shared constants for the windowed watchdog monitor.
// Fault codes and per-channel state encoding.
package wd_pkg;

    localparam logic [2:0] FC_OVR    = 3'b000;
    localparam logic [2:0] FC_NOSW   = 3'b001;
    localparam logic [2:0] FC_EARLY  = 3'b010;
    localparam logic [2:0] FC_SWDROP = 3'b011;
    localparam logic [2:0] FC_TMO    = 3'b100;
    localparam logic [2:0] FC_NONE   = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_OPEN  = 2'd2;
    localparam logic [1:0] ST_FAIL  = 2'd3;

endpackage

// File: rtl/wd_window_channel.sv
// One watchdog channel: service window FSM,
// window counter, service edge detect and fault latch.
module wd_window_channel
    import wd_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int WIN_MIN = 100,
    parameter int WIN_MAX = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       swstat,
    input  logic       wdsrvc,
    input  logic       fwovr,
    input  logic       clrfail,
    output logic       wdfail,
    output logic [2:0] flstat
);

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(WIN_MIN);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(WIN_MAX);
    localparam logic [CNT_W-1:0] SAT_C = '1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             srvd_q, srvd_d;
    logic             srvc_q, srvc_d;
    logic [2:0]       code_q, code_d;

    logic             srvc_edge;
    logic [CNT_W-1:0] cnt_inc;

    // Next-state logic; override wins over every per-channel event.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        srvd_d    = srvd_q;
        code_d    = code_q;
        srvc_d    = wdsrvc;
        srvc_edge = wdsrvc & ~srvc_q;
        cnt_inc   = (cnt_q == SAT_C) ? cnt_q : cnt_q + 1'b1;

        if (fwovr) begin
            state_d = ST_FAIL;
            code_d  = FC_OVR;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (swstat) begin
                        state_d = ST_ARMED;
                        cnt_d   = '0;
                        srvd_d  = 1'b0;
                    end else if (srvc_edge) begin
                        state_d = ST_FAIL;
                        code_d  = FC_NOSW;
                    end
                end
                ST_ARMED, ST_OPEN: begin
                    if (!swstat) begin
                        if (srvd_q) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                            srvd_d  = 1'b0;
                        end else begin
                            state_d = ST_FAIL;
                            code_d  = FC_SWDROP;
                        end
                    end else if (state_q == ST_ARMED) begin
                        if (srvc_edge) begin
                            state_d = ST_FAIL;
                            code_d  = FC_EARLY;
                        end else begin
                            cnt_d = cnt_inc;
                            if (cnt_inc >= MIN_C) begin
                                state_d = ST_OPEN;
                            end
                        end
                    end else begin
                        if (srvc_edge) begin
                            state_d = ST_ARMED;
                            cnt_d   = '0;
                            srvd_d  = 1'b1;
                        end else if (cnt_q >= MAX_C) begin
                            state_d = ST_FAIL;
                            code_d  = FC_TMO;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                ST_FAIL: begin
                    if (clrfail) begin
                        state_d = ST_IDLE;
                        code_d  = FC_NONE;
                        cnt_d   = '0;
                        srvd_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            srvd_q  <= 1'b0;
            srvc_q  <= 1'b0;
            code_q  <= FC_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            srvd_q  <= srvd_d;
            srvc_q  <= srvc_d;
            code_q  <= code_d;
        end
    end

    assign wdfail = (state_q == ST_FAIL);
    assign flstat = code_q;

endmodule

// File: rtl/wd_window_monitor.sv
// Multi-channel windowed watchdog fail detector.
// Replicates one window channel per monitored software task.
module wd_window_monitor
    import wd_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int CNT_W   = 16,
    parameter int WIN_MIN = 100,
    parameter int WIN_MAX = 1000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [NCH-1:0]   SWSTAT,
    input  logic [NCH-1:0]   WDSRVC,
    input  logic             FWOVR,
    input  logic             CLRFAIL,
    output logic [NCH-1:0]   WDFAIL,
    output logic [3*NCH-1:0] FLSTAT,
    output logic             WDFAIL_ANY
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        wd_window_channel #(
            .CNT_W  (CNT_W),
            .WIN_MIN(WIN_MIN),
            .WIN_MAX(WIN_MAX)
        ) u_ch (
            .clk    (CLK),
            .rst_n  (RST_N),
            .swstat (SWSTAT[i]),
            .wdsrvc (WDSRVC[i]),
            .fwovr  (FWOVR),
            .clrfail(CLRFAIL),
            .wdfail (WDFAIL[i]),
            .flstat (FLSTAT[3*i+2:3*i])
        );
    end

    assign WDFAIL_ANY = |WDFAIL;

endmodule

// File: tb/tb_wd_window_monitor.sv
// Directed bench for wd_window_monitor.
// NCH=2, CNT_W=8, WIN_MIN=4, WIN_MAX=10.
module tb_wd_window_monitor;

    logic       CLK;
    logic       RST_N;
    logic [1:0] SWSTAT;
    logic [1:0] WDSRVC;
    logic       FWOVR;
    logic       CLRFAIL;
    logic [1:0] WDFAIL;
    logic [5:0] FLSTAT;
    logic       WDFAIL_ANY;

    int checks;
    int failures;

    wd_window_monitor #(
        .NCH    (2),
        .CNT_W  (8),
        .WIN_MIN(4),
        .WIN_MAX(10)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .SWSTAT    (SWSTAT),
        .WDSRVC    (WDSRVC),
        .FWOVR     (FWOVR),
        .CLRFAIL   (CLRFAIL),
        .WDFAIL    (WDFAIL),
        .FLSTAT    (FLSTAT),
        .WDFAIL_ANY(WDFAIL_ANY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [8:0] obs();
        return {WDFAIL, FLSTAT, WDFAIL_ANY};
    endfunction

    function automatic logic [8:0] ex(input logic [1:0] wf,
                                      input logic [5:0] fl);
        return {wf, fl, |wf};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0; SWSTAT = '0; WDSRVC = '0;
        FWOVR = 1'b0; CLRFAIL = 1'b0;
        step(2);
        checks++;
        if (obs() !== ex(2'b00, 6'b111111)) begin
            failures++;
            $display("FAIL reset_init got=%b exp=%b", obs(), ex(2'b00, 6'b111111));
        end
        RST_N = 1'b1;
        step(1);
        checks++;
        if (obs() !== ex(2'b00, 6'b111111)) begin
            failures++;
            $display("FAIL reset_release got=%b exp=%b", obs(), ex(2'b00, 6'b111111));
        end
    endtask

    task automatic test_legal();
        SWSTAT[0] = 1'b1;
        step(1);
        step(5);
        WDSRVC[0] = 1'b1;
        step(3);
        WDSRVC[0] = 1'b0;
        checks++;
        if (obs() !== ex(2'b00, 6'b111111)) begin
            failures++;
            $display("FAIL legal_srv5_held got=%b exp=%b", obs(), ex(2'b00, 6'b111111));
        end
        step(7);
        WDSRVC[0] = 1'b1;
        step(1);
        WDSRVC[0] = 1'b0;
        checks++;
        if (obs() !== ex(2'b00, 6'b111111)) begin
            failures++;
            $display("FAIL legal_srv9 got=%b exp=%b", obs(), ex(2'b00, 6'b111111));
        end
        SWSTAT[0] = 1'b0;
        step(1);
        checks++;
        if (obs() !== ex(2'b00, 6'b111111)) begin
            failures++;
            $display("FAIL legal_drop got=%b exp=%b", obs(), ex(2'b00, 6'b111111));
        end
        step(15);
        checks++;
        if (obs() !== ex(2'b00, 6'b111111)) begin
            failures++;
            $display("FAIL legal_idle got=%b exp=%b", obs(), ex(2'b00, 6'b111111));
        end
    endtask

    task automatic test_early_nosw();
        SWSTAT[0] = 1'b1;
        step(1);
        step(2);
        WDSRVC[0] = 1'b1;
        step(1);
        WDSRVC[0] = 1'b0;
        checks++;
        if (obs() !== ex(2'b01, 6'b111010)) begin
            failures++;
            $display("FAIL early got=%b exp=%b", obs(), ex(2'b01, 6'b111010));
        end
        WDSRVC[1] = 1'b1;
        step(1);
        WDSRVC[1] = 1'b0;
        checks++;
        if (obs() !== ex(2'b11, 6'b001010)) begin
            failures++;
            $display("FAIL nosw got=%b exp=%b", obs(), ex(2'b11, 6'b001010));
        end
        step(15);
        checks++;
        if (obs() !== ex(2'b11, 6'b001010)) begin
            failures++;
            $display("FAIL first_code_held got=%b exp=%b", obs(), ex(2'b11, 6'b001010));
        end
        SWSTAT = '0;
        CLRFAIL = 1'b1;
        step(1);
        CLRFAIL = 1'b0;
        checks++;
        if (obs() !== ex(2'b00, 6'b111111)) begin
            failures++;
            $display("FAIL clear1 got=%b exp=%b", obs(), ex(2'b00, 6'b111111));
        end
    endtask

    task automatic test_timeout_drop();
        SWSTAT[0] = 1'b1;
        step(1);
        step(10);
        checks++;
        if (obs() !== ex(2'b00, 6'b111111)) begin
            failures++;
            $display("FAIL tmo_before got=%b exp=%b", obs(), ex(2'b00, 6'b111111));
        end
        step(1);
        checks++;
        if (obs() !== ex(2'b01, 6'b111100)) begin
            failures++;
            $display("FAIL tmo got=%b exp=%b", obs(), ex(2'b01, 6'b111100));
        end
        SWSTAT[1] = 1'b1;
        step(1);
        step(3);
        SWSTAT[1] = 1'b0;
        step(1);
        checks++;
        if (obs() !== ex(2'b11, 6'b011100)) begin
            failures++;
            $display("FAIL swdrop got=%b exp=%b", obs(), ex(2'b11, 6'b011100));
        end
    endtask

    task automatic test_rearm();
        CLRFAIL = 1'b1;
        step(1);
        CLRFAIL = 1'b0;
        checks++;
        if (obs() !== ex(2'b00, 6'b111111)) begin
            failures++;
            $display("FAIL clear2 got=%b exp=%b", obs(), ex(2'b00, 6'b111111));
        end
        step(11);
        checks++;
        if (obs() !== ex(2'b00, 6'b111111)) begin
            failures++;
            $display("FAIL rearm_before got=%b exp=%b", obs(), ex(2'b00, 6'b111111));
        end
        step(1);
        checks++;
        if (obs() !== ex(2'b01, 6'b111100)) begin
            failures++;
            $display("FAIL rearm_tmo got=%b exp=%b", obs(), ex(2'b01, 6'b111100));
        end
        SWSTAT = '0;
        CLRFAIL = 1'b1;
        step(1);
        CLRFAIL = 1'b0;
    endtask

    task automatic test_override();
        SWSTAT[1] = 1'b1;
        step(1);
        step(1);
        WDSRVC[1] = 1'b1;
        step(1);
        WDSRVC[1] = 1'b0;
        checks++;
        if (obs() !== ex(2'b10, 6'b010111)) begin
            failures++;
            $display("FAIL ovr_pre got=%b exp=%b", obs(), ex(2'b10, 6'b010111));
        end
        FWOVR = 1'b1;
        step(1);
        checks++;
        if (obs() !== ex(2'b11, 6'b000000)) begin
            failures++;
            $display("FAIL ovr got=%b exp=%b", obs(), ex(2'b11, 6'b000000));
        end
        CLRFAIL = 1'b1;
        step(1);
        checks++;
        if (obs() !== ex(2'b11, 6'b000000)) begin
            failures++;
            $display("FAIL ovr_clr_blocked got=%b exp=%b", obs(), ex(2'b11, 6'b000000));
        end
        SWSTAT = '0;
        FWOVR = 1'b0;
        step(1);
        CLRFAIL = 1'b0;
        checks++;
        if (obs() !== ex(2'b00, 6'b111111)) begin
            failures++;
            $display("FAIL ovr_clr got=%b exp=%b", obs(), ex(2'b00, 6'b111111));
        end
    endtask

    task automatic test_simultaneous();
        SWSTAT[0] = 1'b1;
        step(1);
        step(5);
        SWSTAT[0] = 1'b0;
        WDSRVC[0] = 1'b1;
        step(1);
        WDSRVC[0] = 1'b0;
        checks++;
        if (obs() !== ex(2'b01, 6'b111011)) begin
            failures++;
            $display("FAIL drop_vs_srv got=%b exp=%b", obs(), ex(2'b01, 6'b111011));
        end
        CLRFAIL = 1'b1;
        step(1);
        CLRFAIL = 1'b0;
        SWSTAT[0] = 1'b1;
        step(1);
        step(10);
        WDSRVC[0] = 1'b1;
        step(1);
        WDSRVC[0] = 1'b0;
        checks++;
        if (obs() !== ex(2'b00, 6'b111111)) begin
            failures++;
            $display("FAIL srv_at_max got=%b exp=%b", obs(), ex(2'b00, 6'b111111));
        end
        step(10);
        checks++;
        if (obs() !== ex(2'b00, 6'b111111)) begin
            failures++;
            $display("FAIL restart_before got=%b exp=%b", obs(), ex(2'b00, 6'b111111));
        end
        step(1);
        checks++;
        if (obs() !== ex(2'b01, 6'b111100)) begin
            failures++;
            $display("FAIL restart_tmo got=%b exp=%b", obs(), ex(2'b01, 6'b111100));
        end
    endtask

    task automatic test_reset_mid();
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if (obs() !== ex(2'b00, 6'b111111)) begin
            failures++;
            $display("FAIL reset_async got=%b exp=%b", obs(), ex(2'b00, 6'b111111));
        end
        SWSTAT = '0;
        step(2);
        RST_N = 1'b1;
        step(3);
        checks++;
        if (obs() !== ex(2'b00, 6'b111111)) begin
            failures++;
            $display("FAIL reset_after got=%b exp=%b", obs(), ex(2'b00, 6'b111111));
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_legal();
        test_early_nosw();
        test_timeout_drop();
        test_rearm();
        test_override();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
